// File: rtl/ram_sorter_if.sv
// Single-port RAM bus shared between the sorter and the search datapath.
// The sorter is the master; the RAM side returns registered read data on mem_q.
interface ram_sorter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (output mem_addr, output mem_wdata, output mem_wren, input mem_q);
    modport slave  (input mem_addr, input mem_wdata, input mem_wren, output mem_q);
endinterface

// File: rtl/ram_sorter.sv
// In-place ascending bubble sort of the search RAM, with a shrinking pass limit
// and early exit on a swap-free pass. Owns the RAM bus only while busy.
module ram_sorter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    ram_sorter_if.master      mem,
    output logic              busy,
    output logic              done,
    output logic [8:0]        swap_count,
    output logic [4:0]        pass_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, COMPARE, WRITE_A, WRITE_B, ADVANCE, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] i_inc;
    logic [ADDR_W-1:0] limit;
    logic              swapped;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    assign i_inc = i + ONE;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = COMPARE;
            COMPARE: state_next = (a_reg > mem.mem_q) ? WRITE_A : ADVANCE;
            WRITE_A: state_next = WRITE_B;
            WRITE_B: state_next = ADVANCE;
            ADVANCE: begin
                if (i_inc != limit)                 state_next = LOAD_A;
                else if (!swapped || limit == ONE)  state_next = DONE;
                else                                state_next = LOAD_A;
            end
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_wren  = 1'b0;
        busy          = (state != IDLE) && (state != DONE);
        done          = (state == DONE);
        case (state)
            LOAD_A:  mem.mem_addr = i;
            LOAD_B:  mem.mem_addr = i_inc;
            WRITE_A: begin
                mem.mem_addr  = i;
                mem.mem_wdata = b_reg;
                mem.mem_wren  = 1'b1;
            end
            WRITE_B: begin
                mem.mem_addr  = i_inc;
                mem.mem_wdata = a_reg;
                mem.mem_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after its address, so a[i] is captured in
    // LOAD_B and a[i+1] in COMPARE.
    always_ff @(posedge clk) begin
        if (reset) begin
            i          <= '0;
            limit      <= LAST;
            swapped    <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            swap_count <= '0;
            pass_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i          <= '0;
                        limit      <= LAST;
                        swapped    <= 1'b0;
                        swap_count <= '0;
                        pass_count <= 5'd1;
                    end
                end
                LOAD_B:  a_reg <= mem.mem_q;
                COMPARE: b_reg <= mem.mem_q;
                WRITE_B: begin
                    swapped    <= 1'b1;
                    swap_count <= swap_count + 9'd1;
                end
                ADVANCE: begin
                    if (i_inc != limit) begin
                        i <= i_inc;
                    end else if (swapped && limit != ONE) begin
                        limit      <= limit - ONE;
                        i          <= '0;
                        swapped    <= 1'b0;
                        pass_count <= pass_count + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sorter.sv
// Directed bench for ram_sorter: a behavioural 32x8 RAM with 1-cycle read latency
// and hand-computed expectations for cycle counts, counters and final contents.
module tb_ram_sorter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [8:0] swap_count;
    logic [4:0] pass_count;

    ram_sorter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    ram_sorter #(.ADDR_W(5), .DATA_W(8), .DEPTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem        (bus),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .pass_count (pass_count)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [32];
    logic [7:0] init_vals [32];
    logic       load_req = 1'b0;

    // RAM image is loaded from init_vals on request so only this block writes it.
    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < 32; k++) ram[k] <= init_vals[k];
        end else if (bus.mem_wren) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_q <= ram[bus.mem_addr];
    end

    int assertCount = 0;
    int failCount   = 0;
    int busyCycles;
    int wrenCount;
    int errs;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic loadRam();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic goIdle();
        start = 1'b0;
        @(negedge clk);
    endtask

    // Raise start and count busy cycles and write strobes until done or timeout.
    task automatic runSort();
        int n;
        busyCycles = 0;
        wrenCount  = 0;
        n          = 0;
        start      = 1'b1;
        @(negedge clk);
        while (!done && n < 5000) begin
            if (busy) busyCycles++;
            if (bus.mem_wren) wrenCount++;
            n++;
            @(negedge clk);
        end
        if (n >= 5000) checkOutput("sort_timeout", n, 0);
    endtask

    task automatic applyStimulus();
        goIdle();
        loadRam();
        runSort();
    endtask

    function automatic int countSortedErrs();
        int e = 0;
        for (int k = 0; k < 32; k++) if (ram[k] != 8'(k)) e++;
        return e;
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_wren", bus.mem_wren, 0);
        checkOutput("reset_addr", bus.mem_addr, 0);
        checkOutput("reset_wdata", bus.mem_wdata, 0);
        checkOutput("reset_swaps", swap_count, 0);
        checkOutput("reset_passes", pass_count, 0);
        reset = 1'b0;

        $display("[TB] ascending preload");
        for (int k = 0; k < 32; k++) init_vals[k] = 8'(k);
        applyStimulus();
        checkOutput("asc_busy", busyCycles, 124);
        checkOutput("asc_wren", wrenCount, 0);
        checkOutput("asc_done", done, 1);
        checkOutput("asc_swaps", swap_count, 0);
        checkOutput("asc_passes", pass_count, 1);
        checkOutput("asc_sorted", countSortedErrs(), 0);

        $display("[TB] descending preload");
        for (int k = 0; k < 32; k++) init_vals[k] = 8'(31 - k);
        applyStimulus();
        checkOutput("desc_busy", busyCycles, 2976);
        checkOutput("desc_wren", wrenCount, 992);
        checkOutput("desc_swaps", swap_count, 496);
        checkOutput("desc_passes", pass_count, 31);
        checkOutput("desc_sorted", countSortedErrs(), 0);

        $display("[TB] all words equal");
        for (int k = 0; k < 32; k++) init_vals[k] = 8'd7;
        applyStimulus();
        checkOutput("eq_busy", busyCycles, 124);
        checkOutput("eq_swaps", swap_count, 0);
        checkOutput("eq_passes", pass_count, 1);
        errs = 0;
        for (int k = 0; k < 32; k++) if (ram[k] != 8'd7) errs++;
        checkOutput("eq_contents", errs, 0);

        $display("[TB] large value at address 0");
        for (int k = 0; k < 32; k++) init_vals[k] = 8'(k);
        init_vals[0] = 8'd200;
        applyStimulus();
        checkOutput("big0_busy", busyCycles, 306);
        checkOutput("big0_swaps", swap_count, 31);
        checkOutput("big0_passes", pass_count, 2);
        checkOutput("big0_top", ram[31], 200);
        errs = 0;
        for (int k = 0; k < 31; k++) if (ram[k] != 8'(k + 1)) errs++;
        checkOutput("big0_contents", errs, 0);

        $display("[TB] hold start in DONE");
        wrenCount = 0;
        errs      = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_wren) wrenCount++;
            if (!done || busy) errs++;
            @(negedge clk);
        end
        checkOutput("hold_wren", wrenCount, 0);
        checkOutput("hold_state", errs, 0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("drop_done", done, 0);
        checkOutput("drop_busy", busy, 0);
        runSort();
        checkOutput("resort_busy", busyCycles, 124);
        checkOutput("resort_swaps", swap_count, 0);
        checkOutput("resort_passes", pass_count, 1);

        $display("[TB] reset mid-sort");
        goIdle();
        for (int k = 0; k < 32; k++) init_vals[k] = 8'(31 - k);
        loadRam();
        start = 1'b1;
        @(negedge clk);
        busyCycles = 0;
        while (busy && busyCycles < 49) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("mid_busy_reached", busy, 1);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset_busy", busy, 0);
        checkOutput("mid_reset_wren", bus.mem_wren, 0);
        checkOutput("mid_reset_swaps", swap_count, 0);
        reset = 1'b0;
        @(negedge clk);
        // Eight swaps have moved 31 to address 8; 496 - 8 inversions remain.
        checkOutput("mid_partial_pos8", ram[8], 31);
        runSort();
        checkOutput("mid_swaps", swap_count, 488);
        checkOutput("mid_sorted", countSortedErrs(), 0);

        $display("[TB] reset and start together");
        goIdle();
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("rs_busy", busy, 0);
        checkOutput("rs_done", done, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rs_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
